llc_req_in_stage: RTL
=====================

# llc_req_in_stage

Request-input staging block for the Spandex LLC. It sits directly upstream of the LLC input decoder. It buffers incoming L2/requestor requests in a small FIFO and presents the head request (`llc_req_in_valid_int`, `req_in_addr`) to the decoder. It also owns the stalled-request holding register (`req_in_stalled_valid`) that the decoder drains ahead of new requests. On each decoder accept it latches the selected request into a "current request" register that the downstream LLC pipeline consumes.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and at least 2.
- `MSG_W`, 5: width of the coherence message type.
- `LINE_ADDR_W`, `ADDR_BITS-OFFSET_BITS`: line address width (same as `line_addr_t`).
- `WMASK_W`, `WORDS_PER_LINE`: word-mask width.
- `ID_W`, `NL2_BITS`: requestor ID width.

Ports:
- `clk` in 1: single clock. All state updates on the posedge.
- `rst` in 1: asynchronous reset, active-low.
- `llc_req_in_valid` in 1: upstream request valid.
- `llc_req_in_ready` out 1: upstream ready.
- `llc_req_in_coh_msg` in MSG_W, `llc_req_in_addr` in LINE_ADDR_W, `llc_req_in_word_mask` in WMASK_W, `llc_req_in_req_id` in ID_W: upstream request payload.
- `llc_req_in_valid_int` out 1: FIFO not empty (to decoder).
- `llc_req_in_ready_int` in 1: decoder pops the FIFO head.
- `req_in_addr` out LINE_ADDR_W: address the decoder parses.
- `req_in_stalled_valid` out 1: the stalled register holds a request.
- `clr_req_in_stalled_valid` in 1: from decoder.
- `update_req_in_from_stalled` in 1: from decoder.
- `set_req_in_stalled` in 1: pulse from the pipeline; saves the current request.
- `req_cur_coh_msg` out MSG_W, `req_cur_addr` out LINE_ADDR_W, `req_cur_word_mask` out WMASK_W, `req_cur_req_id` out ID_W: current request.
- `req_cur_valid` out 1: one-cycle pulse. The current register was loaded on the last edge.
- `err_sticky` out 1: protocol violation seen. Cleared only by reset.

## Operation
- **FIFO storage.** DEPTH entries, with `wr_ptr`/`rd_ptr` of log2(DEPTH) bits. Pointers wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Push.** A push happens when `llc_req_in_valid && llc_req_in_ready`.
- **Upstream ready.** `llc_req_in_ready = (count != DEPTH)`. It is a function of state only and has no combinational path from `llc_req_in_ready_int`. When full, no push occurs even if a pop happens in the same cycle.
- **Pop.** A pop happens when `llc_req_in_ready_int && llc_req_in_valid_int`. If `llc_req_in_ready_int` is asserted while the FIFO is empty, it is ignored and `err_sticky` is set.
- **Count update.** Push and pop in the same cycle leave count unchanged; both pointers advance.
- **Decoder outputs.**
  - `llc_req_in_valid_int = (count != 0)`.
  - `req_in_addr = req_in_stalled_valid ? stalled.addr : fifo[rd_ptr].addr`.
  - Both are combinational from registers.
- **Current register load.**
  - On `update_req_in_from_stalled`, load from the stalled register.
  - Else on a pop, load from `fifo[rd_ptr]`.
  - On any load, `req_cur_valid` is 1 in the next cycle; otherwise it is 0.
- **Update and pop in the same cycle.** This is illegal (the decoder makes them exclusive). If it happens:
  - stalled data wins the current register,
  - the pop still dequeues the head,
  - `err_sticky` is set.
- **Stalled register.**
  - `set_req_in_stalled` copies the current register into the stalled register and sets `req_in_stalled_valid` to 1.
  - `clr_req_in_stalled_valid` clears `req_in_stalled_valid`.
  - If set and clear arrive together, set wins: valid stays 1 and the contents are reloaded.
  - A set while valid is already 1 (and no clear) overwrites the contents and sets `err_sticky`.
- **No stall arbitration here.** The decoder alone decides priority between the stalled request and the FIFO head. This block does no MSHR or evict-stall checking.

## Timing
- **Reset values.** Asynchronous reset (`rst` low) forces:
  - count = 0 and both pointers = 0,
  - `llc_req_in_ready = 1` and `llc_req_in_valid_int = 0`,
  - `req_in_stalled_valid = 0`, `req_cur_valid = 0`, `err_sticky = 0`,
  - all `req_cur_*` and stalled fields = 0,
  - `req_in_addr = 0`.
- **FIFO contents at reset.** FIFO storage need not be reset.
- **Reset mid-operation.** Reset during operation discards all buffered and stalled requests immediately (asynchronously), without waiting for a clock edge.
- **Push to head latency.** A request pushed at edge N is visible on `llc_req_in_valid_int`/`req_in_addr` after edge N when the FIFO was empty. There is no same-cycle bypass.
- **Pop to current register latency.** A pop at edge N makes `req_cur_*` valid and `req_cur_valid = 1` during cycle N+1.
- **Stalled register latency.** `set_req_in_stalled` at edge N makes `req_in_stalled_valid` and the stalled address visible on `req_in_addr` from cycle N+1.
- **Throughput.** One push and one pop per cycle are sustained while 0 < count < DEPTH.

## Test plan
- **Reset state.** Assert `rst` low, then release. Check `llc_req_in_ready = 1`, `llc_req_in_valid_int = 0`, `req_in_stalled_valid = 0`, `err_sticky = 0`, and `req_in_addr = 0`.
- **Fill and drain.** Push addresses 0x10, 0x11, 0x12, 0x13 back-to-back with DEPTH = 4 and `ready_int` held low.
  - After the 4th push, `llc_req_in_ready = 0`.
  - A 5th valid beat is not accepted.
  - Popping once per cycle produces `req_cur_addr` 0x10..0x13 in order on consecutive cycles, each with `req_cur_valid = 1`.
- **Wrap-around streaming.** Stream 20 requests with simultaneous push and pop every cycle. Check that order is preserved across pointer wrap, that count stays constant, and that `err_sticky` stays 0.
- **Stall and resume.**
  - Pop 0x20, then pulse `set_req_in_stalled`.
  - Next cycle: `req_in_stalled_valid = 1` and `req_in_addr = 0x20`, even though the head is 0x21.
  - Assert `update_req_in_from_stalled` and `clr_req_in_stalled_valid`. Next cycle: `req_cur_addr = 0x20`, `req_in_stalled_valid = 0`, and `req_in_addr = 0x21`.
- **Simultaneous stall set and clear.** Assert `set_req_in_stalled` and `clr_req_in_stalled_valid` together while valid = 1. Check that valid stays 1 and the stalled address equals the current address.
- **Error cases.** Each of the following, separately, sets `err_sticky = 1`, and the flag remains 1 until reset:
  - pop while empty,
  - `update_req_in_from_stalled` together with a pop,
  - `set_req_in_stalled` while the stalled register is already valid.

Source files
------------

// File: rtl/llc_req_in_stage.sv
// LLC request-input stage: request FIFO, stalled-request holding register and current-request register.
// Latency: push visible at the FIFO head one edge later; pop/update loads req_cur_* on the same edge (req_cur_valid next cycle).
// Backpressure: llc_req_in_ready drops only when the FIFO is full, from registered count alone.
module llc_req_in_stage #(
    parameter int DEPTH       = 4,
    parameter int MSG_W       = 5,
    parameter int LINE_ADDR_W = 26,
    parameter int WMASK_W     = 16,
    parameter int ID_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   llc_req_in_valid,
    output logic                   llc_req_in_ready,
    input  logic [MSG_W-1:0]       llc_req_in_coh_msg,
    input  logic [LINE_ADDR_W-1:0] llc_req_in_addr,
    input  logic [WMASK_W-1:0]     llc_req_in_word_mask,
    input  logic [ID_W-1:0]        llc_req_in_req_id,
    output logic                   llc_req_in_valid_int,
    input  logic                   llc_req_in_ready_int,
    output logic [LINE_ADDR_W-1:0] req_in_addr,
    output logic                   req_in_stalled_valid,
    input  logic                   clr_req_in_stalled_valid,
    input  logic                   update_req_in_from_stalled,
    input  logic                   set_req_in_stalled,
    output logic [MSG_W-1:0]       req_cur_coh_msg,
    output logic [LINE_ADDR_W-1:0] req_cur_addr,
    output logic [WMASK_W-1:0]     req_cur_word_mask,
    output logic [ID_W-1:0]        req_cur_req_id,
    output logic                   req_cur_valid,
    output logic                   err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [MSG_W-1:0]       coh_msg;
        logic [LINE_ADDR_W-1:0] addr;
        logic [WMASK_W-1:0]     word_mask;
        logic [ID_W-1:0]        req_id;
    } req_t;

    req_t             mem [DEPTH];
    req_t             cur_q;
    req_t             stall_q;
    req_t             head;
    req_t             in_req;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             stall_vld_q;
    logic             cur_vld_q;
    logic             err_q;
    logic             push;
    logic             pop;
    logic             err_now;

    assign in_req = '{coh_msg: llc_req_in_coh_msg, addr: llc_req_in_addr,
                      word_mask: llc_req_in_word_mask, req_id: llc_req_in_req_id};
    assign head   = mem[rd_ptr];

    assign llc_req_in_ready     = (count_q != FULL);
    assign llc_req_in_valid_int = (count_q != '0);
    assign push = llc_req_in_valid && llc_req_in_ready;
    assign pop  = llc_req_in_ready_int && llc_req_in_valid_int;

    // Head address is masked when empty so the unreset storage never leaks onto req_in_addr.
    assign req_in_addr = stall_vld_q          ? stall_q.addr :
                         llc_req_in_valid_int ? head.addr    : '0;

    assign err_now = (llc_req_in_ready_int && !llc_req_in_valid_int)
                   || (update_req_in_from_stalled && pop)
                   || (set_req_in_stalled && stall_vld_q && !clr_req_in_stalled_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Stalled data takes the current register even if a pop illegally coincides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q       <= '0;
            cur_vld_q   <= 1'b0;
            stall_q     <= '0;
            stall_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (update_req_in_from_stalled) begin
                cur_q <= stall_q;
            end else if (pop) begin
                cur_q <= head;
            end
            cur_vld_q <= update_req_in_from_stalled || pop;
            if (set_req_in_stalled) begin
                stall_q     <= cur_q;
                stall_vld_q <= 1'b1;
            end else if (clr_req_in_stalled_valid) begin
                stall_vld_q <= 1'b0;
            end
            err_q <= err_q || err_now;
        end
    end

    assign req_in_stalled_valid = stall_vld_q;
    assign req_cur_coh_msg      = cur_q.coh_msg;
    assign req_cur_addr         = cur_q.addr;
    assign req_cur_word_mask    = cur_q.word_mask;
    assign req_cur_req_id       = cur_q.req_id;
    assign req_cur_valid        = cur_vld_q;
    assign err_sticky           = err_q;

endmodule
